// File: rtl/vsram_bank_sched.sv
// vsram_bank_sched: N-bank V-vector SRAM scheduler with a write-back queue, bank-conflict arbitration and RAW hazard handling.
// Ports:
//   clock, reset (async, active-low)
//   rd_valid/rd_ready/rd_row       read request from the element decoder
//   vout_valid/vout                read data, fixed latency 2, no backpressure
//   wr_valid/wr_ready/wr_row/wr_data  write request from the final-result path
//   bank_en/bank_we/bank_addr/bank_wdata/bank_rdata  per-bank 1RW synchronous SRAM port
//   wq_count                       write-queue occupancy
//   rd_stall                       rd_valid & ~rd_ready
// Option: define VSRAM_BYPASS_EN to serve reads that hit the write queue from the queue
// instead of stalling them until the matching entry drains.
module vsram_bank_sched #(
  parameter int NBANK = 4,
  parameter int ROW_W = 11,
  parameter int DATA_W = 48,
  parameter int WQ_DEPTH = 4,
  localparam int LB = $clog2(NBANK),
  localparam int BA_W = ROW_W - LB,
  localparam int CW = $clog2(WQ_DEPTH) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [ROW_W-1:0]        rd_row,
  output logic                    vout_valid,
  output logic [DATA_W-1:0]       vout,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ROW_W-1:0]        wr_row,
  input  logic [DATA_W-1:0]       wr_data,
  output logic [NBANK-1:0]        bank_en,
  output logic [NBANK-1:0]        bank_we,
  output logic [NBANK*BA_W-1:0]   bank_addr,
  output logic [NBANK*DATA_W-1:0] bank_wdata,
  input  logic [NBANK*DATA_W-1:0] bank_rdata,
  output logic [CW-1:0]           wq_count,
  output logic                    rd_stall
);
  localparam int QW = CW - 1;
  logic [ROW_W-1:0] qRow [WQ_DEPTH];
  logic [DATA_W-1:0] qData [WQ_DEPTH];
  logic [QW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [3:0] blkCnt;
  logic [ROW_W-1:0] headRow;
  logic [DATA_W-1:0] headData;
  logic [LB-1:0] headBank, rdBank, p1Bank;
  logic qHit, starve, rdAcc, rdBankAcc, drain, wrAcc, p1Vld;
`ifdef VSRAM_BYPASS_EN
  logic [DATA_W-1:0] qHitData, p1Data;
  logic p1Hit;
`endif

  assign headRow = qRow[head];
  assign headData = qData[head];
  assign headBank = headRow[LB-1:0];
  assign rdBank = rd_row[LB-1:0];
  assign wr_ready = count < CW'(WQ_DEPTH);
  assign wrAcc = wr_valid & wr_ready;
  assign wq_count = count;
  // After 8 consecutive cycles of the head losing its bank to reads, refuse one read so it drains.
  assign starve = blkCnt == 4'd8;

  // Scan oldest to newest so the last match is the newest entry for that row.
  always_comb begin
    qHit = 1'b0;
`ifdef VSRAM_BYPASS_EN
    qHitData = '0;
`endif
    for (int k = 0; k < WQ_DEPTH; k++)
      if (CW'(k) < count && qRow[head + QW'(k)] == rd_row) begin
        qHit = 1'b1;
`ifdef VSRAM_BYPASS_EN
        qHitData = qData[head + QW'(k)];
`endif
      end
  end

`ifdef VSRAM_BYPASS_EN
  assign rd_ready = ~starve;
  assign rdBankAcc = rdAcc & ~qHit;
`else
  // A read to a row still waiting in the queue is held until that entry reaches the bank.
  assign rd_ready = ~starve & ~qHit;
  assign rdBankAcc = rdAcc;
`endif
  assign rdAcc = rd_valid & rd_ready;
  assign rd_stall = rd_valid & ~rd_ready;
  assign drain = (count != '0) & ~(rdBankAcc & (rdBank == headBank));

  always_comb begin
    bank_en = '0;
    bank_we = '0;
    bank_addr = '0;
    bank_wdata = '0;
    if (rdBankAcc) begin
      bank_en[rdBank] = 1'b1;
      bank_addr[rdBank*BA_W +: BA_W] = rd_row[ROW_W-1:LB];
    end
    if (drain) begin
      bank_en[headBank] = 1'b1;
      bank_we[headBank] = 1'b1;
      bank_addr[headBank*BA_W +: BA_W] = headRow[ROW_W-1:LB];
      bank_wdata[headBank*DATA_W +: DATA_W] = headData;
    end
  end

  always_ff @(posedge clock) begin
    if (wrAcc) begin
      qRow[tail] <= wr_row;
      qData[tail] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      blkCnt <= '0;
      p1Vld <= 1'b0;
      p1Bank <= '0;
      vout_valid <= 1'b0;
      vout <= '0;
`ifdef VSRAM_BYPASS_EN
      p1Hit <= 1'b0;
      p1Data <= '0;
`endif
    end else begin
      if (wrAcc) tail <= tail + QW'(1);
      if (drain) head <= head + QW'(1);
      count <= count + CW'(wrAcc) - CW'(drain);
      blkCnt <= (count != '0 && !drain) ? blkCnt + 4'd1 : 4'd0;
      p1Vld <= rdAcc;
      p1Bank <= rdBank;
      vout_valid <= p1Vld;
`ifdef VSRAM_BYPASS_EN
      p1Hit <= qHit;
      p1Data <= qHitData;
      if (p1Vld) vout <= p1Hit ? p1Data : bank_rdata[p1Bank*DATA_W +: DATA_W];
`else
      if (p1Vld) vout <= bank_rdata[p1Bank*DATA_W +: DATA_W];
`endif
    end
  end
endmodule

// File: tb/tb_vsram_bank_sched.sv
// tb_vsram_bank_sched: directed bench for vsram_bank_sched with an SRAM model and read/write scoreboards.
module tb_vsram_bank_sched;
  typedef struct { logic [47:0] data; int cyc; } rd_t;
  typedef struct { logic [10:0] row; logic [47:0] data; } wr_t;

  logic clock = 0, reset = 1;
  logic rd_valid = 0, wr_valid = 0;
  logic [10:0] rd_row = 0, wr_row = 0;
  logic [47:0] wr_data = 0;
  logic rd_ready, vout_valid, wr_ready, rd_stall;
  logic [47:0] vout;
  logic [3:0] bank_en, bank_we;
  logic [35:0] bank_addr;
  logic [191:0] bank_wdata, bank_rdata;
  logic [2:0] wq_count;
  int nVec = 0, nMis = 0, cyc = 0;
  rd_t expQ[$];
  wr_t wq[$];
  logic [47:0] committed [int];
  logic [47:0] mem [4][512];
  bit wrt [4][512];

  vsram_bank_sched dut (
    .clock(clock), .reset(reset), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_row(rd_row),
    .vout_valid(vout_valid), .vout(vout), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_row(wr_row), .wr_data(wr_data), .bank_en(bank_en), .bank_we(bank_we),
    .bank_addr(bank_addr), .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
    .wq_count(wq_count), .rd_stall(rd_stall)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [47:0] pat(input logic [10:0] r);
    return r == 11'd5 ? 48'h000123_000456 : {13'h0, r, 13'h1A5, r};
  endfunction

  // Latest value of a row: newest pending write, else the last committed write, else the preload pattern.
  function automatic logic [47:0] model(input logic [10:0] r);
    logic [47:0] v = committed.exists(int'(r)) ? committed[int'(r)] : pat(r);
    foreach (wq[i]) if (wq[i].row == r) v = wq[i].data;
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nMis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 1RW synchronous SRAM per bank, preloaded with pat() for never-written words.
  always @(posedge clock)
    for (int b = 0; b < 4; b++)
      if (bank_en[b]) begin
        if (bank_we[b]) begin
          mem[b][bank_addr[b*9 +: 9]] <= bank_wdata[b*48 +: 48];
          wrt[b][bank_addr[b*9 +: 9]] <= 1'b1;
        end else
          bank_rdata[b*48 +: 48] <= wrt[b][bank_addr[b*9 +: 9]] ? mem[b][bank_addr[b*9 +: 9]]
                                                                : pat({bank_addr[b*9 +: 9], 2'(b)});
      end

  always @(negedge clock or negedge reset) begin
    rd_t e;
    wr_t w;
    if (!reset) begin
      expQ.delete();
      wq.delete();
    end else begin
      if (vout_valid) begin
        check("vout_pending", 64'(expQ.size() != 0), 1);
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          check("vout", vout, e.data);
          check("vout_latency", cyc, e.cyc + 2);
        end
      end
      for (int b = 0; b < 4; b++)
        if (bank_en[b] && bank_we[b]) begin
          check("wr_pending", 64'(wq.size() != 0), 1);
          if (wq.size() != 0) begin
            w = wq.pop_front();
            check("wr_row", {bank_addr[b*9 +: 9], 2'(b)}, w.row);
            check("wr_data", bank_wdata[b*48 +: 48], w.data);
            committed[int'(w.row)] = w.data;
          end
        end
      if (rd_valid && rd_ready) begin
        e.data = model(rd_row);
        e.cyc = cyc;
        expQ.push_back(e);
      end
      if (wr_valid && wr_ready) begin
        w.row = wr_row;
        w.data = wr_data;
        wq.push_back(w);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic doRead(input logic [10:0] row, input string tag);
    bit ok = 0;
    rd_valid = 1;
    rd_row = row;
    for (int i = 0; i < 20 && !ok; i++) begin
      #2;
      ok = rd_ready;
      tick();
    end
    rd_valid = 0;
    check(tag, 64'(ok), 1);
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 40 && wq_count != 0; i++) tick();
    check(tag, wq_count, 0);
  endtask

  initial begin
    int drops, firstDrop, wi, ri;
    bit sawFull, sawFour, accW, accR;
    #1 reset = 0;
    #2;
    check("rst_rd_ready", rd_ready, 1);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_count", wq_count, 0);
    check("rst_vout_valid", vout_valid, 0);
    check("rst_bank_en", bank_en, 0);
    check("rst_rd_stall", rd_stall, 0);
    @(posedge clock);
    #1 reset = 1;
    tick();
    // Read row 5: bank 1, local address 1, data returned two cycles later.
    rd_valid = 1;
    rd_row = 5;
    #2;
    check("r5_bank_en", bank_en, 4'b0010);
    check("r5_bank_we", bank_we, 0);
    check("r5_addr", bank_addr[9 +: 9], 1);
    tick();
    rd_valid = 0;
    tick();
    #2;
    check("r5_vout_valid", vout_valid, 1);
    check("r5_vout", vout, 48'h000123_000456);
    tick();
    // Write row 8, read it back the next cycle.
    wr_valid = 1;
    wr_row = 8;
    wr_data = 48'hABCDEF_123456;
    tick();
    wr_valid = 0;
    rd_valid = 1;
    rd_row = 8;
    #2;
`ifdef VSRAM_BYPASS_EN
    check("raw_rd_stall", rd_stall, 0);
    check("raw_no_bank_read", bank_en & ~bank_we, 0);
    tick();
`else
    check("raw_rd_stall", rd_stall, 1);
    check("raw_drain_we", bank_we, 4'b0001);
    tick();
    #2;
    check("raw_accept", rd_ready, 1);
    check("raw_bank_read", bank_en & ~bank_we, 4'b0001);
    tick();
`endif
    rd_valid = 0;
    tick();
    tick();
    // A write accepted in the same cycle as a read of that row stays invisible to the read.
    rd_valid = 1;
    rd_row = 200;
    wr_valid = 1;
    wr_row = 200;
    wr_data = 48'h200200_200200;
    tick();
    rd_valid = 0;
    wr_valid = 0;
    waitDrain("vis_drain");
    doRead(200, "vis_readback");
    tick();
    // Back-to-back writes to bank 0 against a continuous read stream on bank 0.
    drops = 0; firstDrop = 0; wi = 0; ri = 0; sawFull = 0; sawFour = 0;
    wr_valid = 1; wr_row = 32; wr_data = {24'd0, 24'hC0FFEE};
    rd_valid = 1; rd_row = 400;
    for (int c = 1; c <= 12; c++) begin
      #2;
      if (!rd_ready) begin
        drops++;
        if (firstDrop == 0) firstDrop = c;
      end
      if (!wr_ready) sawFull = 1;
      if (wq_count == 4) sawFour = 1;
      accW = wr_valid && wr_ready;
      accR = rd_ready;
      tick();
      if (accW) wi++;
      if (accR) ri++;
      wr_valid = wi < 5;
      wr_row = 11'(32 + 4 * wi);
      wr_data = {24'(wi), 24'hC0FFEE};
      rd_row = 11'(400 + 4 * ri);
    end
    rd_valid = 0;
    wr_valid = 0;
    check("starve_drops", drops, 1);
    check("starve_first", firstDrop, 10);
    check("starve_full", 64'(sawFull), 1);
    check("starve_count4", 64'(sawFour), 1);
    check("starve_writes", wi, 5);
    waitDrain("starve_drain");
    doRead(48, "starve_readback");
    tick();
    // Read to bank 2 alongside a drain to bank 3.
    wr_valid = 1; wr_row = 3; wr_data = 48'h333333_000003;
    tick();
    wr_valid = 0;
    rd_valid = 1;
    rd_row = 6;
    #2;
    check("dual_bank_en", bank_en, 4'b1100);
    check("dual_bank_we", bank_we, 4'b1000);
    check("dual_addr3", bank_addr[27 +: 9], 0);
    check("dual_addr2", bank_addr[18 +: 9], 1);
    tick();
    rd_valid = 0;
    tick();
    // Enqueue and drain in the same cycle at occupancy 2.
    wr_valid = 1; wr_row = 1; wr_data = 48'h111111_000001; rd_valid = 1; rd_row = 401;
    tick();
    wr_row = 5; wr_data = 48'h555555_000005; rd_row = 405;
    tick();
    wr_row = 9; wr_data = 48'h999999_000009; rd_valid = 0;
    #2;
    check("simul_count_before", wq_count, 2);
    check("simul_drain_we", bank_we, 4'b0010);
    tick();
    wr_valid = 0;
    #2;
    check("simul_count_after", wq_count, 2);
    tick();
    waitDrain("simul_drain");
    doRead(5, "simul_readback");
    // Ten writes to one row wrap the queue pointers; the last one must win.
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1; wr_row = 77; wr_data = {24'(i), 24'h000077};
      tick();
    end
    wr_valid = 0;
    waitDrain("wrap_drain");
    doRead(77, "wrap_readback");
    tick();
    tick();
    // Three queued writes, then reset mid-cycle discards them.
    wr_valid = 1; wr_row = 100; wr_data = 48'hDEAD00_000100; rd_valid = 1; rd_row = 420;
    tick();
    wr_row = 104; wr_data = 48'hDEAD00_000104; rd_row = 424;
    tick();
    wr_row = 108; wr_data = 48'hDEAD00_000108; rd_row = 428;
    tick();
    wr_valid = 0;
    rd_valid = 0;
    #1;
    check("mid_count3", wq_count, 3);
    #1 reset = 0;
    #1;
    check("mid_count0", wq_count, 0);
    check("mid_vout_valid", vout_valid, 0);
    check("mid_bank_en", bank_en, 0);
    check("mid_bank_we", bank_we, 0);
    check("mid_bank_addr", 64'(bank_addr), 0);
    check("mid_wr_ready", wr_ready, 1);
    check("mid_rd_ready", rd_ready, 1);
    tick();
    reset = 1;
    for (int i = 0; i < 6; i++) tick();
    doRead(100, "mid_readback");
    for (int i = 0; i < 5; i++) tick();
    check("end_reads_pending", expQ.size(), 0);
    check("end_writes_pending", wq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule

// File: doc/vsram_bank_sched.md
Name: vsram_bank_sched

Overview:
- Parametrised scheduler for the banked V-vector SRAM of the sparse complex mat-vec engine.
- Generalises the fixed 4-bank V read arbiter and V write scheduler into one block with N banks.
- Adds a write-back queue, read/write bank-conflict arbitration and read-after-write hazard handling.
- Reads come from the element decoder (row index). Writes come from the final-result path (row, complex 24+24 data).

Parameters:
- NBANK, 4, number of V banks (power of 2, >=2); bank = row[log2(NBANK)-1:0].
- ROW_W, 11, global row index width.
- DATA_W, 48, element width ({real[23:0], imag[23:0]}).
- WQ_DEPTH, 4, write-queue entries (power of 2, >=2).
- Derived: BA_W = ROW_W - log2(NBANK), bank-local address = row >> log2(NBANK).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd_valid  in  1  read request.
- rd_ready  out  1  read accepted when rd_valid & rd_ready.
- rd_row  in  ROW_W  row to read.
- vout_valid  out  1  read data valid, single-cycle pulse; no backpressure.
- vout  out  DATA_W  read data.
- wr_valid  in  1  write request.
- wr_ready  out  1  write-queue space available.
- wr_row  in  ROW_W  row to write.
- wr_data  in  DATA_W  data to write.
- bank_en  out  NBANK  per-bank access enable (1RW synchronous SRAM).
- bank_we  out  NBANK  per-bank write enable (subset of bank_en).
- bank_addr  out  NBANK*BA_W  per-bank address, bank b at [b*BA_W +: BA_W].
- bank_wdata  out  NBANK*DATA_W  per-bank write data.
- bank_rdata  in  NBANK*DATA_W  per-bank read data, valid the cycle after bank_en & ~bank_we.
- wq_count  out  clog2(WQ_DEPTH)+1  queue occupancy.
- rd_stall  out  1  rd_valid & ~rd_ready.

Behaviour:
- Reset (reset=0, asynchronous):
  - Queue emptied; pipeline valids cleared; pending writes discarded.
  - All outputs 0, except wr_ready=1 and rd_ready=1.
- Read path:
  - Accepted read in cycle T drives bank_en[b]=1, bank_we[b]=0, bank_addr[b]=local address in T.
  - Bank index and hit flag are registered. rdata is captured in T+1.
  - vout_valid=1 in T+2 with vout = bank b's data. Fixed latency 2, one read per cycle, in order.
- Write queue:
  - FIFO. wr_ready = (wq_count < WQ_DEPTH); accept on wr_valid & wr_ready.
  - An entry becomes eligible to drain the cycle after it is enqueued.
  - Head drains (bank_en=bank_we=1 on its bank, address, wdata) when the queue is non-empty and no read is accepted to the same bank that cycle.
  - Reads have priority over writes. At most one drain per cycle.
  - Simultaneous enqueue and drain: count unchanged. Full queue with simultaneous drain: wr_ready stays 0 that cycle (no same-cycle reuse).
- Hazard, build without the optional feature:
  - rd_ready=0 while rd_row equals the row of any valid queue entry.
  - The read is held until that entry drains. It is then accepted and returns the new data.
  - rd_ready depends combinationally on rd_row.
- Visibility: a read sees only writes accepted in strictly earlier cycles. A same-cycle write to the same row is not visible to that read.
- Starvation guard: if the head has been blocked by reads for 8 consecutive cycles, rd_ready=0 for one cycle to force the drain.

Optional Feature:
- Macro: VSRAM_BYPASS_EN.
- Defined:
  - A read whose row hits a queue entry is accepted immediately.
  - Data comes from the newest matching entry, snapshotted at accept; no bank access is made.
  - vout is still returned at T+2, keeping latency fixed.
  - Hazard stalls are removed; the starvation-guard stall remains.
- Undefined: stall behaviour as above.

Test Plan:
- Reset, then read row 5 (NBANK=4) -> bank_en=4'b0010, bank_addr[1]=1; bank returns 48'h000123_000456 -> vout_valid at T+2 with that value.
- Write row 8 then read row 8 the next cycle -> no bypass: rd_stall=1 until the write drains, vout=new data; bypass: no stall, vout=new data at T+2, bank_en=0 for the read.
- 5 back-to-back writes to bank 0 while reads to bank 0 are issued every cycle -> wq_count reaches 4, wr_ready=0, starvation guard drops rd_ready once after 8 blocked cycles, queue drains.
- Read to bank 2 and queue head for bank 3 in the same cycle -> both bank_en bits set, bank_we=4'b1000.
- Queue holds 3 entries and reset is pulsed low mid-stream -> all outputs 0 asynchronously, wq_count=0, no bank writes after release.
- Simultaneous write enqueue and drain at count=2 -> count stays 2; FIFO order preserved across wrap-around after 10 writes.
